// File: rtl/block_threshold_sequencer.sv
// -----------------------------------------------------------------------------
// block_threshold_sequencer
//
// Collects per-tile block scores for two heads and tracks running min/max/sum.
// When the last tile of a job has been accepted, a restoring serial divider
// (one quotient bit per cycle, both heads in parallel) produces the mean.
// One more cycle then registers the two block-pruning thresholds, which are
// selected by the latched pruning ratio.
//
// Optional feature macro: BTS_ROUND_MEAN_EN
//   defined   : dividend = sat(sum + (num_tiles >> 1)), so the mean rounds half-up
//   undefined : mean = floor(sum / num_tiles)
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   start          in   begin a job (sampled only while idle)
//   num_tiles      in   tiles in the job, latched on start
//   pruning_ratio  in   0:0% 1:25% 2:50% 3:75% 4:100%, latched on start
//   tile_valid     in   tile_score0/1 valid
//   tile_ready     out  a tile is accepted this cycle if tile_valid is high
//   tile_score0/1  in   head-0 / head-1 score of the current tile
//   threshold0/1   out  head thresholds, updated only on the done cycle
//   busy           out  job in progress
//   done           out  one-cycle completion pulse
//   error          out  zero-tile job or ratio > 4
//   sat            out  a per-head sum saturated during the job
// -----------------------------------------------------------------------------
module block_threshold_sequencer #(
  parameter int width           = 8,
  parameter int FRACTIONAL_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*width-1:0]   num_tiles,
  input  logic [2:0]           pruning_ratio,
  input  logic                 tile_valid,
  output logic                 tile_ready,
  input  logic [2*width-1:0]   tile_score0,
  input  logic [2*width-1:0]   tile_score1,
  output logic [2*width-1:0]   threshold0,
  output logic [2*width-1:0]   threshold1,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 sat
);

  localparam int WD  = 2 * width;
  localparam int DCW = (WD > 2) ? $clog2(WD) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(WD - 1);
  localparam logic [DCW-1:0] DIV_ONE  = DCW'(1);
  localparam logic [WD-1:0]  ONE_W    = WD'(1);

  // Scores are fixed-point; the fraction is carried through untouched, so the
  // only constraint is that it fits in the score word.
  if (FRACTIONAL_BITS < 0 || FRACTIONAL_BITS > 2 * width) begin : g_frac_range
    $error("FRACTIONAL_BITS must lie in 0..2*width");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACCUM, ST_DIV, ST_THRESH, ST_DONE
  } state_e;

  // Full-width sum with carry out.
  function automatic logic [WD:0] wide_add(input logic [WD-1:0] a, input logic [WD-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Clamp a carry-extended sum to the all-ones maximum.
  function automatic logic [WD-1:0] clip(input logic [WD:0] s);
    return s[WD] ? {WD{1'b1}} : s[WD-1:0];
  endfunction

  // (a+b)>>1 evaluated one bit wider so the midpoint never overflows.
  function automatic logic [WD-1:0] half_sum(input logic [WD-1:0] a, input logic [WD-1:0] b);
    return WD'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

  // One restoring-division step: returns {quotient_bit, new_remainder}.
  // When the trial value is >= divisor the true difference fits in WD bits,
  // so a WD-bit modular subtract gives the exact remainder.
  function automatic logic [WD:0] div_step(input logic [WD-1:0] rem, input logic din,
                                           input logic [WD-1:0] dvs);
    logic [WD:0] trial;
    trial = {rem, din};
    if (trial >= {1'b0, dvs}) begin
      return {1'b1, trial[WD-1:0] - dvs};
    end else begin
      return {1'b0, trial[WD-1:0]};
    end
  endfunction

  state_e          state_q, state_d;
  logic [WD-1:0]   num_q, num_d;
  logic [2:0]      ratio_q, ratio_d;
  logic [WD-1:0]   cnt_q, cnt_d;
  logic [DCW-1:0]  div_cnt_q, div_cnt_d;
  logic [WD-1:0]   min0_q, min0_d, min1_q, min1_d;
  logic [WD-1:0]   max0_q, max0_d, max1_q, max1_d;
  logic [WD-1:0]   sum0_q, sum0_d, sum1_q, sum1_d;
  logic [WD-1:0]   rem0_q, rem0_d, rem1_q, rem1_d;
  logic [WD-1:0]   quo0_q, quo0_d, quo1_q, quo1_d;
  logic            sat_acc_q, sat_acc_d;
  logic [WD-1:0]   thr0_q, thr0_d, thr1_q, thr1_d;
  logic            done_q, done_d, busy_q, busy_d;
  logic            err_q, err_d, sat_q, sat_d;
  logic            ready_q, ready_d;

  logic [WD:0]     sum0_w_s, sum1_w_s;
  logic [WD:0]     step0_s, step1_s;
  logic            xfer_s;

  assign xfer_s   = tile_valid && ready_q;
  assign sum0_w_s = wide_add(sum0_q, tile_score0);
  assign sum1_w_s = wide_add(sum1_q, tile_score1);
  // The quotient register is pre-loaded with the dividend and shifted left;
  // its MSB is the next dividend bit to bring down.
  assign step0_s  = div_step(rem0_q, quo0_q[WD-1], num_q);
  assign step1_s  = div_step(rem1_q, quo1_q[WD-1], num_q);

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    ratio_d   = ratio_q;
    cnt_d     = cnt_q;
    div_cnt_d = div_cnt_q;
    min0_d    = min0_q;
    min1_d    = min1_q;
    max0_d    = max0_q;
    max1_d    = max1_q;
    sum0_d    = sum0_q;
    sum1_d    = sum1_q;
    rem0_d    = rem0_q;
    rem1_d    = rem1_q;
    quo0_d    = quo0_q;
    quo1_d    = quo1_q;
    sat_acc_d = sat_acc_q;
    thr0_d    = thr0_q;
    thr1_d    = thr1_q;
    done_d    = 1'b0;
    err_d     = err_q;
    sat_d     = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d   = num_tiles;
          ratio_d = pruning_ratio;
          sat_d   = 1'b0;
          if (num_tiles == {WD{1'b0}}) begin
            state_d = ST_DONE;
            thr0_d  = {WD{1'b0}};
            thr1_d  = {WD{1'b0}};
            err_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_ACCUM;
            err_d     = 1'b0;
            min0_d    = {WD{1'b1}};
            min1_d    = {WD{1'b1}};
            max0_d    = {WD{1'b0}};
            max1_d    = {WD{1'b0}};
            sum0_d    = {WD{1'b0}};
            sum1_d    = {WD{1'b0}};
            cnt_d     = {WD{1'b0}};
            sat_acc_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (xfer_s) begin
          min0_d    = (tile_score0 < min0_q) ? tile_score0 : min0_q;
          min1_d    = (tile_score1 < min1_q) ? tile_score1 : min1_q;
          max0_d    = (tile_score0 > max0_q) ? tile_score0 : max0_q;
          max1_d    = (tile_score1 > max1_q) ? tile_score1 : max1_q;
          sum0_d    = clip(sum0_w_s);
          sum1_d    = clip(sum1_w_s);
          sat_acc_d = sat_acc_q | sum0_w_s[WD] | sum1_w_s[WD];
          cnt_d     = cnt_q + ONE_W;
          if (cnt_q == num_q - ONE_W) begin
            state_d   = ST_DIV;
            div_cnt_d = {DCW{1'b0}};
            rem0_d    = {WD{1'b0}};
            rem1_d    = {WD{1'b0}};
`ifdef BTS_ROUND_MEAN_EN
            quo0_d    = clip(wide_add(sum0_d, num_q >> 1));
            quo1_d    = clip(wide_add(sum1_d, num_q >> 1));
`else
            quo0_d    = sum0_d;
            quo1_d    = sum1_d;
`endif
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DIV: begin
        rem0_d    = step0_s[WD-1:0];
        rem1_d    = step1_s[WD-1:0];
        quo0_d    = {quo0_q[WD-2:0], step0_s[WD]};
        quo1_d    = {quo1_q[WD-2:0], step1_s[WD]};
        div_cnt_d = div_cnt_q + DIV_ONE;
        if (div_cnt_q == DIV_LAST) begin
          state_d = ST_THRESH;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_THRESH: begin
        // quo0_q/quo1_q now hold the per-head means.
        state_d = ST_DONE;
        done_d  = 1'b1;
        sat_d   = sat_acc_q;
        case (ratio_q)
          3'd0: begin
            thr0_d = min0_q;
            thr1_d = min1_q;
          end
          3'd1: begin
            thr0_d = half_sum(min0_q, quo0_q);
            thr1_d = half_sum(min1_q, quo1_q);
          end
          3'd2: begin
            thr0_d = quo0_q;
            thr1_d = quo1_q;
          end
          3'd3: begin
            thr0_d = half_sum(max0_q, quo0_q);
            thr1_d = half_sum(max1_q, quo1_q);
          end
          3'd4: begin
            thr0_d = max0_q;
            thr1_d = max1_q;
          end
          default: begin
            thr0_d = max0_q;
            thr1_d = max1_q;
            err_d  = 1'b1;
          end
        endcase
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_ACCUM);
    busy_d  = (state_d != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q     <= {WD{1'b0}};
      ratio_q   <= 3'd0;
      cnt_q     <= {WD{1'b0}};
      div_cnt_q <= {DCW{1'b0}};
      min0_q    <= {WD{1'b0}};
      min1_q    <= {WD{1'b0}};
      max0_q    <= {WD{1'b0}};
      max1_q    <= {WD{1'b0}};
      sum0_q    <= {WD{1'b0}};
      sum1_q    <= {WD{1'b0}};
      rem0_q    <= {WD{1'b0}};
      rem1_q    <= {WD{1'b0}};
      quo0_q    <= {WD{1'b0}};
      quo1_q    <= {WD{1'b0}};
      sat_acc_q <= 1'b0;
      thr0_q    <= {WD{1'b0}};
      thr1_q    <= {WD{1'b0}};
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      sat_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      num_q     <= num_d;
      ratio_q   <= ratio_d;
      cnt_q     <= cnt_d;
      div_cnt_q <= div_cnt_d;
      min0_q    <= min0_d;
      min1_q    <= min1_d;
      max0_q    <= max0_d;
      max1_q    <= max1_d;
      sum0_q    <= sum0_d;
      sum1_q    <= sum1_d;
      rem0_q    <= rem0_d;
      rem1_q    <= rem1_d;
      quo0_q    <= quo0_d;
      quo1_q    <= quo1_d;
      sat_acc_q <= sat_acc_d;
      thr0_q    <= thr0_d;
      thr1_q    <= thr1_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      sat_q     <= sat_d;
      ready_q   <= ready_d;
    end
  end

  assign tile_ready = ready_q;
  assign threshold0 = thr0_q;
  assign threshold1 = thr1_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_block_threshold_sequencer.sv
module tb_block_threshold_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, tile_valid, tile_ready;
  logic [15:0] num_tiles, tile_score0, tile_score1, threshold0, threshold1;
  logic [2:0]  pruning_ratio;
  logic        busy, done, error, sat;

  block_threshold_sequencer #(.width(8), .FRACTIONAL_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
    .pruning_ratio(pruning_ratio), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_score0(tile_score0), .tile_score1(tile_score1),
    .threshold0(threshold0), .threshold1(threshold1),
    .busy(busy), .done(done), .error(error), .sat(sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] t0;
    logic [15:0] t1;
    logic        err;
    logic        sat;
    int          dc;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [15:0] tile0 [64];
  logic [15:0] tile1 [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic over the whole tile list of one head.
  function automatic void head_ref(input int n, input int ratio, input bit h,
                                   output logic [15:0] thr, output bit satf);
    longint sm = 0, mn = 65535, mx = 0, dv, mean, v;
    for (int i = 0; i < n; i++) begin
      v  = h ? longint'(tile1[i]) : longint'(tile0[i]);
      sm = sm + v;
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    satf = (sm > 65535);
    if (satf) sm = 65535;
    dv = sm;
`ifdef BTS_ROUND_MEAN_EN
    dv = sm + n / 2;
    if (dv > 65535) dv = 65535;
`endif
    mean = dv / n;
    case (ratio)
      0: thr = 16'(mn);
      1: thr = 16'((mn + mean) / 2);
      2: thr = 16'(mean);
      3: thr = 16'((mx + mean) / 2);
      default: thr = 16'(mx);
    endcase
  endfunction

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still %0d expected 0", busy);
    end
  endtask

  // Issues one job; the expected response goes to the scoreboard.
  task automatic run_job(input int n, input int ratio, input int gap, input bit poke);
    exp_t e;
    bit   s0f, s1f;
    int   s_cyc, last_cyc, i, budget;
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1;
    num_tiles = 16'(n);
    pruning_ratio = 3'(ratio);
    s_cyc = cyc;
    if (n == 0) begin
      e.t0 = 16'd0; e.t1 = 16'd0; e.err = 1'b1; e.sat = 1'b0; e.dc = s_cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("zero_job_tile_ready", 64'(tile_ready), 64'd0);
      end
      return;
    end
    head_ref(n, ratio, 1'b0, e.t0, s0f);
    head_ref(n, ratio, 1'b1, e.t1, s1f);
    e.sat = s0f | s1f;
    e.err = (ratio > 4);
    @(posedge clk); #1;
    start = poke;
    num_tiles = 16'($urandom_range(1, 50));
    pruning_ratio = 3'($urandom_range(0, 7));
    i = 0; budget = 600; last_cyc = 0;
    while (i < n && budget > 0) begin
      if (gap > 0 && $urandom_range(0, 99) < gap) begin
        tile_valid  = 1'b0;
        tile_score0 = 16'($urandom);
        tile_score1 = 16'($urandom);
      end else begin
        tile_valid  = 1'b1;
        tile_score0 = tile0[i];
        tile_score1 = tile1[i];
      end
      @(negedge clk);
      if (tile_valid && tile_ready) begin
        last_cyc = cyc;
        i++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      budget--;
    end
    tile_valid = 1'b0;
    if (i < n) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: accepted %0d tiles expected %0d", i, n);
    end else begin
      e.dc = last_cyc + 18;
      sb.push_back(e);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  exp_t        mon_e;
  logic        prev_done = 1'b0, prev_rst = 1'b1;
  logic [15:0] pt0 = 16'd0, pt1 = 16'd0;
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("threshold0", 64'(threshold0), 64'(mon_e.t0));
          chk("threshold1", 64'(threshold1), 64'(mon_e.t1));
          chk("error", 64'(error), 64'(mon_e.err));
          chk("sat", 64'(sat), 64'(mon_e.sat));
          chk("done_cycle", 64'(cyc), 64'(mon_e.dc));
        end
        if (prev_done) begin
          checks++;
          errors++;
          $display("FAIL done_pulse_width: got 2+ cycles expected 1");
        end
      end else if (!prev_rst && (threshold0 !== pt0 || threshold1 !== pt1)) begin
        checks++;
        errors++;
        $display("FAIL threshold_hold: got %0d/%0d expected %0d/%0d", threshold0, threshold1, pt0, pt1);
      end
    end
    prev_done <= done;
    prev_rst  <= rst;
    pt0       <= threshold0;
    pt1       <= threshold1;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_threshold0"}, 64'(threshold0), 64'd0);
    chk({tag, "_threshold1"}, 64'(threshold1), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_sat"}, 64'(sat), 64'd0);
    chk({tag, "_tile_ready"}, 64'(tile_ready), 64'd0);
  endtask

  int ratios [5];
  int exp_t0 [5];

  initial begin
    rst = 1'b1; start = 1'b0; tile_valid = 1'b0; num_tiles = 16'd0;
    pruning_ratio = 3'd0; tile_score0 = 16'd0; tile_score1 = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Reference tile set from the datasheet example.
    tile0[0] = 16'd10; tile0[1] = 16'd20; tile0[2] = 16'd30; tile0[3] = 16'd40;
    for (int k = 0; k < 4; k++) tile1[k] = 16'd5;
    ratios = '{2, 0, 1, 3, 4};
    exp_t0 = '{25, 10, 17, 32, 40};
    for (int k = 0; k < 5; k++) begin
      run_job(4, ratios[k], 0, 1'b0);
      wait_idle();
      chk("example_thr0", 64'(threshold0), 64'(exp_t0[k]));
      chk("example_thr1", 64'(threshold1), 64'd5);
    end

    run_job(0, 2, 0, 1'b0);
    wait_idle();
    chk("zero_job_error", 64'(error), 64'd1);

    tile0[0] = 16'd1; tile0[1] = 16'd2; tile0[2] = 16'd2;
    for (int k = 0; k < 3; k++) tile1[k] = 16'($urandom_range(0, 500));
    run_job(3, 2, 40, 1'b1);
    wait_idle();
`ifdef BTS_ROUND_MEAN_EN
    chk("mean_3tiles", 64'(threshold0), 64'd2);
`else
    chk("mean_3tiles", 64'(threshold0), 64'd1);
`endif

    tile0[0] = 16'd65535; tile0[1] = 16'd65535;
    tile1[0] = 16'd3;     tile1[1] = 16'd4;
    run_job(2, 2, 0, 1'b0);
    wait_idle();
    chk("sat_flag", 64'(sat), 64'd1);
    chk("sat_thr0", 64'(threshold0), 64'd32767);

    tile0[0] = 16'd10; tile0[1] = 16'd20; tile0[2] = 16'd30; tile0[3] = 16'd40;
    for (int k = 0; k < 4; k++) tile1[k] = 16'd5;
    run_job(4, 6, 0, 1'b0);
    wait_idle();
    chk("bad_ratio_thr0", 64'(threshold0), 64'd40);
    chk("bad_ratio_error", 64'(error), 64'd1);

    // Abort a job while the divider is running.
    run_job(4, 2, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    chk_all_zero("abort");
    run_job(4, 2, 30, 1'b1);
    wait_idle();
    chk("after_abort_thr0", 64'(threshold0), 64'd25);

    for (int j = 0; j < 20; j++) begin
      int n;
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        tile0[k] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(30000, 65535))
                                               : 16'($urandom_range(0, 1000));
        tile1[k] = 16'($urandom);
      end
      run_job(n, $urandom_range(0, 7), 30, 1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
